dm_sba_master: RTL and testbench

Bus initiator for the debug module's System Bus Access (SBA) path. It turns debugger-side sbaddress/sbdata register events into single 64-bit-bus read and write transactions, using a request/grant/rvalid handshake. It performs size and alignment checking, byte-lane steering, autoincrement and sticky error reporting. It is the initiating counterpart of the debug-memory responders (ROM, program buffer) and sits between the DM CSR logic and the SoC system-bus crossbar.

---
 rtl/dm_pkg.sv | 63 ++++++
 rtl/dm_sba_master.sv | 149 ++++++++++++++
 tb/tb_dm_sba_master.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dm_pkg.sv
// Shared types, error codes and byte-lane helpers for the debug module's
// system-bus access path. The lane helpers live here so the CSR block can
// reuse the same steering rules as the bus initiator.
package dm_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        READ_REQ   = 3'd1,
        WRITE_REQ  = 3'd2,
        READ_WAIT  = 3'd3,
        WRITE_WAIT = 3'd4
    } sba_state_e;

    typedef enum logic [2:0] {
        SBERR_NONE  = 3'd0,
        SBERR_ALIGN = 3'd3,
        SBERR_SIZE  = 3'd4,
        SBERR_OTHER = 3'd7
    } sberror_e;

    localparam logic [2:0] SBACCESS_8  = 3'd0;
    localparam logic [2:0] SBACCESS_16 = 3'd1;
    localparam logic [2:0] SBACCESS_32 = 3'd2;
    localparam logic [2:0] SBACCESS_64 = 3'd3;

    // Byte enables for an access of (1 << access) bytes starting at lane off.
    function automatic logic [7:0] be_gen(input logic [1:0] access, input logic [2:0] off);
        logic [3:0] nbytes;
        logic [8:0] mask;
        nbytes = 4'd1 << access;
        mask   = (9'd1 << nbytes) - 9'd1;
        return mask[7:0] << off;
    endfunction

    // Move right-aligned data up to byte lane off.
    function automatic logic [63:0] lane_shift(input logic [63:0] data, input logic [2:0] off);
        return data << {off, 3'b000};
    endfunction

    // Bring lane off down to bit 0 and zero everything above the access size.
    function automatic logic [63:0] lane_extract(input logic [63:0] data, input logic [1:0] access,
                                                 input logic [2:0] off);
        logic [63:0] shifted;
        shifted = data >> {off, 3'b000};
        case (access)
            2'd0:    return {56'd0, shifted[7:0]};
            2'd1:    return {48'd0, shifted[15:0]};
            2'd2:    return {32'd0, shifted[31:0]};
            default: return shifted;
        endcase
    endfunction

    // Address bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] align_mask(input logic [1:0] access);
        case (access)
            2'd0:    return 3'b000;
            2'd1:    return 3'b001;
            2'd2:    return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

endpackage

// File: rtl/dm_sba_master.sv
// System Bus Access initiator: turns sbaddress/sbdata register events into
// single read/write transactions on a 64-bit req/gnt/rvalid bus, with size
// and alignment checks, lane steering, autoincrement and error pulses.
module dm_sba_master
    import dm_pkg::*;
#(
    parameter int BusWidth  = 64,
    parameter int AddrWidth = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [AddrWidth-1:0] sbaddress_i,
    input  logic                 sbaddress_we_i,
    input  logic [BusWidth-1:0]  sbdata_i,
    input  logic                 sbdata_we_i,
    input  logic                 sbdata_re_i,
    input  logic [2:0]           sbaccess_i,
    input  logic                 sbreadonaddr_i,
    input  logic                 sbreadondata_i,
    input  logic                 sbautoincrement_i,
    input  logic [2:0]           sberror_i,
    input  logic                 sbbusyerror_i,
    output logic [AddrWidth-1:0] sbaddress_o,
    output logic [BusWidth-1:0]  sbdata_o,
    output logic                 sbdata_valid_o,
    output logic                 sbbusy_o,
    output logic [2:0]           sberror_o,
    output logic                 sberror_valid_o,
    output logic                 sbbusyerror_o,
    output logic                 req_o,
    output logic [AddrWidth-1:0] addr_o,
    output logic                 we_o,
    output logic [7:0]           be_o,
    output logic [BusWidth-1:0]  wdata_o,
    input  logic                 gnt_i,
    input  logic                 rvalid_i,
    input  logic [BusWidth-1:0]  rdata_i,
    input  logic                 err_i
);

    sba_state_e           state_reg;
    logic [AddrWidth-1:0] addr_reg;
    logic [BusWidth-1:0]  sbdata_reg;
    logic [1:0]           size_reg;
    logic [2:0]           off_reg;
    logic                 autoinc_reg;

    logic                 trig_addr;
    logic                 trig_write;
    logic                 trig_rdata;
    logic                 any_trig;
    logic                 start_read;
    logic                 start_write;
    logic                 blocked;
    logic                 size_bad;
    logic                 align_bad;
    logic [AddrWidth-1:0] access_addr;

    // Prioritise the register events and pre-check the access they would start.
    always_comb begin
        trig_addr   = sbaddress_we_i;
        trig_write  = sbdata_we_i && !sbaddress_we_i;
        trig_rdata  = sbdata_re_i && sbreadondata_i && !sbaddress_we_i && !sbdata_we_i;
        any_trig    = sbaddress_we_i || sbdata_we_i || (sbdata_re_i && sbreadondata_i);
        start_read  = (trig_addr && sbreadonaddr_i) || trig_rdata;
        start_write = trig_write;
        access_addr = trig_addr ? sbaddress_i : addr_reg;
        blocked     = (sberror_i != 3'd0) || sbbusyerror_i;
        size_bad    = sbaccess_i[2];
        align_bad   = (access_addr[2:0] & align_mask(sbaccess_i[1:0])) != 3'b000;
    end

    // Access FSM with registered bus outputs and one-cycle status pulses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg       <= IDLE;
            addr_reg        <= '0;
            sbdata_reg      <= '0;
            size_reg        <= 2'd0;
            off_reg         <= 3'd0;
            autoinc_reg     <= 1'b0;
            sbdata_valid_o  <= 1'b0;
            sberror_o       <= SBERR_NONE;
            sberror_valid_o <= 1'b0;
            sbbusyerror_o   <= 1'b0;
            req_o           <= 1'b0;
            addr_o          <= '0;
            we_o            <= 1'b0;
            be_o            <= 8'd0;
            wdata_o         <= '0;
        end else begin
            sbdata_valid_o  <= 1'b0;
            sberror_o       <= SBERR_NONE;
            sberror_valid_o <= 1'b0;
            sbbusyerror_o   <= (state_reg != IDLE) && any_trig;
            case (state_reg)
                IDLE: begin
                    if (trig_addr) addr_reg <= sbaddress_i;
                    if ((start_read || start_write) && !blocked) begin
                        if (size_bad) begin
                            sberror_o       <= SBERR_SIZE;
                            sberror_valid_o <= 1'b1;
                        end else if (align_bad) begin
                            sberror_o       <= SBERR_ALIGN;
                            sberror_valid_o <= 1'b1;
                        end else begin
                            req_o       <= 1'b1;
                            we_o        <= start_write;
                            addr_o      <= {access_addr[AddrWidth-1:3], 3'b000};
                            be_o        <= be_gen(sbaccess_i[1:0], access_addr[2:0]);
                            wdata_o     <= start_write ? lane_shift(sbdata_i, access_addr[2:0]) : '0;
                            size_reg    <= sbaccess_i[1:0];
                            off_reg     <= access_addr[2:0];
                            autoinc_reg <= sbautoincrement_i;
                            state_reg   <= start_write ? WRITE_REQ : READ_REQ;
                        end
                    end
                end
                READ_REQ, WRITE_REQ: begin
                    if (gnt_i) begin
                        req_o     <= 1'b0;
                        state_reg <= (state_reg == READ_REQ) ? READ_WAIT : WRITE_WAIT;
                    end
                end
                READ_WAIT, WRITE_WAIT: begin
                    if (rvalid_i) begin
                        state_reg <= IDLE;
                        if (err_i) begin
                            sberror_o       <= SBERR_OTHER;
                            sberror_valid_o <= 1'b1;
                        end else begin
                            if (state_reg == READ_WAIT) begin
                                sbdata_reg     <= lane_extract(rdata_i, size_reg, off_reg);
                                sbdata_valid_o <= 1'b1;
                            end
                            if (autoinc_reg) addr_reg <= addr_reg + (64'd1 << size_reg);
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign sbaddress_o = addr_reg;
    assign sbdata_o    = sbdata_reg;
    assign sbbusy_o    = (state_reg != IDLE);

endmodule

// File: tb/tb_dm_sba_master.sv
// Directed bench for the SBA initiator: each task drives one scenario and
// compares outputs one cycle at a time against hand-computed values.
module tb_dm_sba_master;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [63:0] sbaddress_i = '0;
    logic        sbaddress_we_i = 1'b0;
    logic [63:0] sbdata_i = '0;
    logic        sbdata_we_i = 1'b0;
    logic        sbdata_re_i = 1'b0;
    logic [2:0]  sbaccess_i = 3'd0;
    logic        sbreadonaddr_i = 1'b0;
    logic        sbreadondata_i = 1'b0;
    logic        sbautoincrement_i = 1'b0;
    logic [2:0]  sberror_i = 3'd0;
    logic        sbbusyerror_i = 1'b0;
    logic [63:0] sbaddress_o;
    logic [63:0] sbdata_o;
    logic        sbdata_valid_o;
    logic        sbbusy_o;
    logic [2:0]  sberror_o;
    logic        sberror_valid_o;
    logic        sbbusyerror_o;
    logic        req_o;
    logic [63:0] addr_o;
    logic        we_o;
    logic [7:0]  be_o;
    logic [63:0] wdata_o;
    logic        gnt_i = 1'b0;
    logic        rvalid_i = 1'b0;
    logic [63:0] rdata_i = '0;
    logic        err_i = 1'b0;

    int checks = 0;
    int passes = 0;
    int handshakes = 0;
    logic [63:0] last_read = '0;

    dm_sba_master #(.BusWidth(64), .AddrWidth(64)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .sbaddress_i(sbaddress_i), .sbaddress_we_i(sbaddress_we_i),
        .sbdata_i(sbdata_i), .sbdata_we_i(sbdata_we_i), .sbdata_re_i(sbdata_re_i),
        .sbaccess_i(sbaccess_i), .sbreadonaddr_i(sbreadonaddr_i),
        .sbreadondata_i(sbreadondata_i), .sbautoincrement_i(sbautoincrement_i),
        .sberror_i(sberror_i), .sbbusyerror_i(sbbusyerror_i),
        .sbaddress_o(sbaddress_o), .sbdata_o(sbdata_o), .sbdata_valid_o(sbdata_valid_o),
        .sbbusy_o(sbbusy_o), .sberror_o(sberror_o), .sberror_valid_o(sberror_valid_o),
        .sbbusyerror_o(sbbusyerror_o), .req_o(req_o), .addr_o(addr_o), .we_o(we_o),
        .be_o(be_o), .wdata_o(wdata_o), .gnt_i(gnt_i), .rvalid_i(rvalid_i),
        .rdata_i(rdata_i), .err_i(err_i)
    );

    always #5 clk_i = ~clk_i;

    // Count accepted bus requests, sampled away from the active edge.
    always @(negedge clk_i) if (rst_ni && req_o && gnt_i) handshakes++;

    // Advance one cycle; inputs set and outputs read after this belong to the new cycle.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic load_addr(input logic [63:0] a);
        sbaddress_i = a; sbaddress_we_i = 1'b1;
        step();
        sbaddress_we_i = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (req_o !== 1'b0 || sbbusy_o !== 1'b0) $display("FAIL reset_bus req=%b busy=%b required 0 0", req_o, sbbusy_o); else passes++;
        step(); step();
        checks++; if (sbaddress_o !== 64'd0 || sbdata_o !== 64'd0 || sberror_valid_o !== 1'b0 || be_o !== 8'd0)
            $display("FAIL reset_state addr=%h data=%h errv=%b be=%h required all 0", sbaddress_o, sbdata_o, sberror_valid_o, be_o);
        else passes++;
        rst_ni = 1'b1;
        step();
    endtask

    task automatic test_read32();
        sbaccess_i = 3'd2; sbreadonaddr_i = 1'b1;
        load_addr(64'h8000_0004);                       // cycle N was the trigger
        checks++; if (req_o !== 1'b1 || addr_o !== 64'h8000_0000 || be_o !== 8'hF0 || we_o !== 1'b0)
            $display("FAIL read32_req req=%b addr=%h be=%h we=%b required 1 80000000 f0 0", req_o, addr_o, be_o, we_o);
        else passes++;
        checks++; if (sbbusy_o !== 1'b1) $display("FAIL read32_busy1 busy=%b required 1", sbbusy_o); else passes++;
        step(); gnt_i = 1'b1;                           // grant one cycle late
        checks++; if (req_o !== 1'b1 || sbbusy_o !== 1'b1) $display("FAIL read32_hold req=%b busy=%b required 1 1", req_o, sbbusy_o); else passes++;
        step(); gnt_i = 1'b0; rvalid_i = 1'b1; rdata_i = 64'hDEADBEEF_12345678;
        checks++; if (req_o !== 1'b0 || sbbusy_o !== 1'b1 || sbdata_valid_o !== 1'b0)
            $display("FAIL read32_wait req=%b busy=%b valid=%b required 0 1 0", req_o, sbbusy_o, sbdata_valid_o);
        else passes++;
        step(); rvalid_i = 1'b0;
        checks++; if (sbdata_o !== 64'h0000_0000_DEADBEEF || sbdata_valid_o !== 1'b1 || sbbusy_o !== 1'b0)
            $display("FAIL read32_data data=%h valid=%b busy=%b required 00000000deadbeef 1 0", sbdata_o, sbdata_valid_o, sbbusy_o);
        else passes++;
        last_read = 64'h0000_0000_DEADBEEF;
        step();
        checks++; if (sbdata_valid_o !== 1'b0) $display("FAIL read32_pulse valid=%b required 0", sbdata_valid_o); else passes++;
        sbreadonaddr_i = 1'b0;
    endtask

    task automatic test_byte_write();
        sbaccess_i = 3'd0;
        load_addr(64'h13);
        sbdata_i = 64'hAB; sbdata_we_i = 1'b1;
        checks++; if (sbaddress_o !== 64'h13 || sbbusy_o !== 1'b0) $display("FAIL bw_load addr=%h busy=%b required 13 0", sbaddress_o, sbbusy_o); else passes++;
        step(); sbdata_we_i = 1'b0; gnt_i = 1'b1;
        checks++; if (req_o !== 1'b1 || we_o !== 1'b1 || be_o !== 8'h08 || wdata_o !== 64'h0000_0000_AB00_0000 || addr_o !== 64'h10)
            $display("FAIL bw_req req=%b we=%b be=%h wdata=%h addr=%h required 1 1 08 00000000ab000000 10", req_o, we_o, be_o, wdata_o, addr_o);
        else passes++;
        step(); gnt_i = 1'b0; rvalid_i = 1'b1;
        step(); rvalid_i = 1'b0;
        checks++; if (sbbusy_o !== 1'b0 || sbdata_valid_o !== 1'b0 || sbaddress_o !== 64'h13 || sbdata_o !== last_read)
            $display("FAIL bw_done busy=%b valid=%b addr=%h data=%h required 0 0 13 %h", sbbusy_o, sbdata_valid_o, sbaddress_o, sbdata_o, last_read);
        else passes++;
    endtask

    task automatic test_autoincrement();
        logic [63:0] exp_addr;
        sbaccess_i = 3'd3; sbreadondata_i = 1'b1; sbautoincrement_i = 1'b1;
        load_addr(64'h1000);
        exp_addr = 64'h1000;
        for (int i = 0; i < 3; i++) begin
            sbdata_re_i = 1'b1;                          // cycle N
            step(); sbdata_re_i = 1'b0; gnt_i = 1'b1;   // N+1
            checks++; if (req_o !== 1'b1 || addr_o !== exp_addr) $display("FAIL ainc_addr%0d req=%b addr=%h required 1 %h", i, req_o, addr_o, exp_addr); else passes++;
            step(); gnt_i = 1'b0; rvalid_i = 1'b1; rdata_i = 64'h1111_2222_0000_0000 + 64'(i);
            step(); rvalid_i = 1'b0;                     // N+3
            exp_addr = exp_addr + 64'd8;
            checks++; if (sbdata_o !== 64'h1111_2222_0000_0000 + 64'(i) || sbdata_valid_o !== 1'b1 || sbbusy_o !== 1'b0 || sbaddress_o !== exp_addr)
                $display("FAIL ainc_done%0d data=%h valid=%b busy=%b addr=%h required %h 1 0 %h", i, sbdata_o, sbdata_valid_o, sbbusy_o, sbaddress_o,
                         64'h1111_2222_0000_0000 + 64'(i), exp_addr);
            else passes++;
            last_read = 64'h1111_2222_0000_0000 + 64'(i);
        end
        checks++; if (sbaddress_o !== 64'h1018) $display("FAIL ainc_final addr=%h required 1018", sbaddress_o); else passes++;
        sbreadondata_i = 1'b0;
    endtask

    task automatic test_wrap();
        sbaccess_i = 3'd3; sbreadonaddr_i = 1'b1; sbautoincrement_i = 1'b1;
        load_addr(64'hFFFF_FFFF_FFFF_FFF8);
        gnt_i = 1'b1;
        checks++; if (addr_o !== 64'hFFFF_FFFF_FFFF_FFF8 || be_o !== 8'hFF) $display("FAIL wrap_req addr=%h be=%h required fffffffffffffff8 ff", addr_o, be_o); else passes++;
        step(); gnt_i = 1'b0; rvalid_i = 1'b1; rdata_i = 64'h0123_4567_89AB_CDEF;
        step(); rvalid_i = 1'b0;
        checks++; if (sbaddress_o !== 64'd0 || sbdata_o !== 64'h0123_4567_89AB_CDEF) $display("FAIL wrap_done addr=%h data=%h required 0 0123456789abcdef", sbaddress_o, sbdata_o); else passes++;
        last_read = 64'h0123_4567_89AB_CDEF;
        sbreadonaddr_i = 1'b0;
    endtask

    task automatic test_errors();
        int hs0;
        hs0 = handshakes;
        sbreadonaddr_i = 1'b1; sbautoincrement_i = 1'b1;
        sbaccess_i = 3'd5;
        load_addr(64'h2000);
        checks++; if (sberror_valid_o !== 1'b1 || sberror_o !== 3'd4 || req_o !== 1'b0 || sbbusy_o !== 1'b0 || sbaddress_o !== 64'h2000)
            $display("FAIL err_size errv=%b err=%0d req=%b busy=%b addr=%h required 1 4 0 0 2000", sberror_valid_o, sberror_o, req_o, sbbusy_o, sbaddress_o);
        else passes++;
        sbaccess_i = 3'd2;
        load_addr(64'h2);
        checks++; if (sberror_valid_o !== 1'b1 || sberror_o !== 3'd3 || req_o !== 1'b0 || sbaddress_o !== 64'h2)
            $display("FAIL err_align errv=%b err=%0d req=%b addr=%h required 1 3 0 2", sberror_valid_o, sberror_o, req_o, sbaddress_o);
        else passes++;
        step();
        checks++; if (sberror_valid_o !== 1'b0 || req_o !== 1'b0 || handshakes != hs0)
            $display("FAIL err_quiet errv=%b req=%b grants=%0d required 0 0 %0d", sberror_valid_o, req_o, handshakes, hs0);
        else passes++;
        // Sticky CSR error blocks the access but the address still loads.
        sberror_i = 3'd3; sbaccess_i = 3'd3;
        load_addr(64'h2800);
        checks++; if (req_o !== 1'b0 || sberror_valid_o !== 1'b0 || sbaddress_o !== 64'h2800)
            $display("FAIL err_blocked req=%b errv=%b addr=%h required 0 0 2800", req_o, sberror_valid_o, sbaddress_o);
        else passes++;
        sberror_i = 3'd0;
        // Bus error response.
        load_addr(64'h3000);
        gnt_i = 1'b1;
        step(); gnt_i = 1'b0; rvalid_i = 1'b1; err_i = 1'b1; rdata_i = 64'h5555_5555_5555_5555;
        step(); rvalid_i = 1'b0; err_i = 1'b0;
        checks++; if (sberror_valid_o !== 1'b1 || sberror_o !== 3'd7 || sbdata_valid_o !== 1'b0 || sbdata_o !== last_read || sbaddress_o !== 64'h3000 || sbbusy_o !== 1'b0)
            $display("FAIL err_bus errv=%b err=%0d valid=%b data=%h addr=%h busy=%b required 1 7 0 %h 3000 0",
                     sberror_valid_o, sberror_o, sbdata_valid_o, sbdata_o, sbaddress_o, sbbusy_o, last_read);
        else passes++;
        sbreadonaddr_i = 1'b0; sbautoincrement_i = 1'b0;
    endtask

    task automatic test_busy_stall();
        int hs0;
        int unstable;
        sbaccess_i = 3'd2;
        load_addr(64'h4000);
        hs0 = handshakes; unstable = 0;
        sbdata_i = 64'h5566_7788; sbdata_we_i = 1'b1;    // cycle N
        step();                                          // N+1, second trigger while busy
        sbdata_i = 64'h9999_9999;
        for (int c = 0; c < 5; c++) begin
            if (req_o !== 1'b1 || we_o !== 1'b1 || addr_o !== 64'h4000 || be_o !== 8'h0F || wdata_o !== 64'h5566_7788) unstable++;
            if (c == 1) begin
                checks++; if (sbbusyerror_o !== 1'b1) $display("FAIL busyerr_pulse busyerr=%b required 1", sbbusyerror_o); else passes++;
                sbdata_we_i = 1'b0;
            end
            if (c == 2) begin
                checks++; if (sbbusyerror_o !== 1'b0) $display("FAIL busyerr_clear busyerr=%b required 0", sbbusyerror_o); else passes++;
            end
            step();
        end
        checks++; if (unstable != 0) $display("FAIL stall_stable unstable_cycles=%0d required 0", unstable); else passes++;
        gnt_i = 1'b1;
        step(); gnt_i = 1'b0; rvalid_i = 1'b1;
        step(); rvalid_i = 1'b0;
        step();
        checks++; if (handshakes != hs0 + 1 || sbbusy_o !== 1'b0 || req_o !== 1'b0)
            $display("FAIL stall_once grants=%0d busy=%b req=%b required %0d 0 0", handshakes - hs0, sbbusy_o, req_o, 1);
        else passes++;
        // Reset while a request is outstanding.
        sbdata_we_i = 1'b1; sbdata_i = 64'h1;
        step(); sbdata_we_i = 1'b0;
        checks++; if (req_o !== 1'b1) $display("FAIL rst_pre req=%b required 1", req_o); else passes++;
        #2 rst_ni = 1'b0;
        #1;
        checks++; if (req_o !== 1'b0 || sbbusy_o !== 1'b0 || sbaddress_o !== 64'd0 || sbdata_o !== 64'd0 || be_o !== 8'd0 || addr_o !== 64'd0 || wdata_o !== 64'd0)
            $display("FAIL rst_mid req=%b busy=%b addr=%h data=%h be=%h baddr=%h wdata=%h required all 0",
                     req_o, sbbusy_o, sbaddress_o, sbdata_o, be_o, addr_o, wdata_o);
        else passes++;
        step();
        rst_ni = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_read32();
        test_byte_write();
        test_autoincrement();
        test_wrap();
        test_errors();
        test_busy_stall();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
